// File: rtl/gt_uint16_serial.sv
// gt_uint16_serial: bit-serial unsigned A > B comparator, LSB-first through a 1-bit borrow cell,
// with valid/ready handshakes on both the operand and the result side.
module gt_uint16_serial #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             Y
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t state, state_nx;
    logic [WIDTH-1:0] sa, sb;
    logic [CW-1:0] cnt;
    logic brw;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: state_nx = in_valid ? RUN : IDLE;
            RUN: state_nx = (cnt == LAST) ? DONE : RUN;
            DONE: state_nx = out_ready ? IDLE : DONE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        in_ready = state == IDLE;
        out_valid = state == DONE;
        Y = out_valid & brw;
    end

    // brw tracks the running borrow of B - A; its final value is 1 exactly when A > B.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sa <= '0;
            sb <= '0;
            brw <= 1'b0;
            cnt <= '0;
        end else if (state == IDLE && in_valid) begin
            sa <= A;
            sb <= B;
            brw <= 1'b0;
            cnt <= '0;
        end else if (state == RUN) begin
            brw <= (sa[0] & ~sb[0]) | (~(sa[0] ^ sb[0]) & brw);
            sa <= sa >> 1;
            sb <= sb >> 1;
            cnt <= (cnt == LAST) ? cnt : cnt + 1'b1;
        end
    end
endmodule
